// File: rtl/hwpe_vadd_job_ctrl.sv
// Job sequencer for the vector-add streaming datapath: takes one descriptor, starts all
// load sources and the sink together, then tracks beats and per-stream done pulses.
module hwpe_vadd_job_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NB_OPERANDS    = 2,
  parameter int unsigned LEN_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     job_valid_i,
  output logic                     job_ready_o,
  input  logic [NB_OPERANDS*32-1:0] job_addr_src_i,
  input  logic [31:0]              job_addr_dst_i,
  input  logic [LEN_W-1:0]         job_len_i,
  input  logic [NB_OPERANDS-1:0]   src_ready_start_i,
  input  logic [NB_OPERANDS-1:0]   src_done_i,
  output logic [NB_OPERANDS-1:0]   src_req_start_o,
  output logic [NB_OPERANDS*32-1:0] src_addr_o,
  input  logic                     sink_ready_start_i,
  input  logic                     sink_done_i,
  output logic                     sink_req_start_o,
  output logic [31:0]              dst_addr_o,
  output logic [LEN_W-1:0]         len_o,
  input  logic                     beat_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [1:0]               err_code_o,
  output logic [31:0]              cycles_o
);

  // state | meaning
  // IDLE  | waiting for a descriptor, job_ready_o high
  // CFG   | alignment and zero-length checks on the latched descriptor
  // START | waiting for every stream to be startable, then pulse start
  // RUN   | counting cycles/beats, collecting per-stream done bits
  // DONE  | one-cycle successful completion pulse
  // ERR   | one-cycle completion pulse with err_o latched
  typedef enum logic [2:0] {
    ST_IDLE, ST_CFG, ST_START, ST_RUN, ST_DONE, ST_ERR
  } state_t;

  localparam int unsigned BCNT_W     = LEN_W + 1;
  localparam logic [31:0] ALIGN_MASK = 32'(DATA_WIDTH / 8 - 1);
  localparam logic [31:0] TIMEOUT    = 32'(TIMEOUT_CYCLES);

  state_t                     state_q, state_d;
  logic [NB_OPERANDS*32-1:0]  src_addr_q, src_addr_d;
  logic [31:0]                dst_addr_q, dst_addr_d;
  logic [LEN_W-1:0]           len_q, len_d;
  logic                       err_q, err_d;
  logic [1:0]                 err_code_q, err_code_d;
  logic [31:0]                cycles_q, cycles_d, cycles_inc;
  logic [BCNT_W-1:0]          beat_cnt_q, beat_cnt_d;
  logic [NB_OPERANDS:0]       done_bits_q, done_bits_d, done_now;
  logic                       all_ready;
  logic                       misaligned;

  always_comb begin
    state_d          = state_q;
    src_addr_d       = src_addr_q;
    dst_addr_d       = dst_addr_q;
    len_d            = len_q;
    err_d            = err_q;
    err_code_d       = err_code_q;
    cycles_d         = cycles_q;
    beat_cnt_d       = beat_cnt_q;
    done_bits_d      = done_bits_q;
    src_req_start_o  = '0;
    sink_req_start_o = 1'b0;

    all_ready  = (&src_ready_start_i) & sink_ready_start_i;
    done_now   = done_bits_q | {sink_done_i, src_done_i};
    cycles_inc = (&cycles_q) ? cycles_q : cycles_q + 32'd1;
    misaligned = |(dst_addr_q & ALIGN_MASK);
    for (int i = 0; i < int'(NB_OPERANDS); i++) begin
      if (|(src_addr_q[32*i +: 32] & ALIGN_MASK)) misaligned = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (job_valid_i) begin
          src_addr_d  = job_addr_src_i;
          dst_addr_d  = job_addr_dst_i;
          len_d       = job_len_i;
          err_d       = 1'b0;
          err_code_d  = 2'd0;
          cycles_d    = '0;
          beat_cnt_d  = '0;
          done_bits_d = '0;
          state_d     = ST_CFG;
        end
      end
      ST_CFG: begin
        if (misaligned) begin
          err_d      = 1'b1;
          err_code_d = 2'd1;
          state_d    = ST_ERR;
        end else if (len_q == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        src_req_start_o  = {NB_OPERANDS{all_ready}};
        sink_req_start_o = all_ready;
        if (all_ready) state_d = ST_RUN;
      end
      ST_RUN: begin
        cycles_d    = cycles_inc;
        done_bits_d = done_now;
        if (beat_i && !(&beat_cnt_q)) beat_cnt_d = beat_cnt_q + BCNT_W'(1);
        // completion is checked before the timeout so a coincident last done wins
        if (&done_now) begin
          if (beat_cnt_d == {1'b0, len_q}) begin
            state_d = ST_DONE;
          end else begin
            err_d      = 1'b1;
            err_code_d = 2'd3;
            state_d    = ST_ERR;
          end
        end else if (TIMEOUT_CYCLES != 0 && cycles_inc == TIMEOUT) begin
          err_d      = 1'b1;
          err_code_d = 2'd2;
          state_d    = ST_ERR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q     <= ST_IDLE;
      src_addr_q  <= '0;
      dst_addr_q  <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
      cycles_q    <= '0;
      beat_cnt_q  <= '0;
      done_bits_q <= '0;
    end else begin
      state_q     <= state_d;
      src_addr_q  <= src_addr_d;
      dst_addr_q  <= dst_addr_d;
      len_q       <= len_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      cycles_q    <= cycles_d;
      beat_cnt_q  <= beat_cnt_d;
      done_bits_q <= done_bits_d;
    end
  end

  assign job_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;
  assign cycles_o    = cycles_q;
  assign src_addr_o  = src_addr_q;
  assign dst_addr_o  = dst_addr_q;
  assign len_o       = len_q;

endmodule

// File: tb/tb_hwpe_vadd_job_ctrl.sv
// Scoreboard bench for hwpe_vadd_job_ctrl: stimulus queues expected completions,
// a monitor checks each done_o pulse plus start-pulse lock-step and count.
module tb_hwpe_vadd_job_ctrl;

  logic        clk = 1'b0;
  logic        rst, clear;
  logic        job_valid, job_ready;
  logic [63:0] job_addr_src;
  logic [31:0] job_addr_dst;
  logic [15:0] job_len;
  logic [1:0]  src_ready_start, src_done, src_req_start;
  logic [63:0] src_addr;
  logic        sink_ready_start, sink_done, sink_req_start;
  logic [31:0] dst_addr;
  logic [15:0] len;
  logic        beat, busy, done, err;
  logic [1:0]  err_code;
  logic [31:0] cycles;

  int total = 0;
  int bad   = 0;
  int starts = 0;

  typedef struct {
    logic        err;
    logic [1:0]  code;
    logic [31:0] cycles;
    int          starts;
  } exp_t;
  exp_t sb_q[$];

  hwpe_vadd_job_ctrl #(
    .DATA_WIDTH(32), .NB_OPERANDS(2), .LEN_W(16), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .job_valid_i(job_valid), .job_ready_o(job_ready),
    .job_addr_src_i(job_addr_src), .job_addr_dst_i(job_addr_dst), .job_len_i(job_len),
    .src_ready_start_i(src_ready_start), .src_done_i(src_done),
    .src_req_start_o(src_req_start), .src_addr_o(src_addr),
    .sink_ready_start_i(sink_ready_start), .sink_done_i(sink_done),
    .sink_req_start_o(sink_req_start), .dst_addr_o(dst_addr), .len_o(len),
    .beat_i(beat), .busy_o(busy), .done_o(done), .err_o(err),
    .err_code_o(err_code), .cycles_o(cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic e, input logic [1:0] c, input logic [31:0] cy, input int st);
    exp_t x;
    x.err = e; x.code = c; x.cycles = cy; x.starts = st;
    sb_q.push_back(x);
  endtask

  // Leaves the bench in the CFG cycle (one cycle after the accepting edge).
  task automatic accept(input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d, input logic [15:0] l);
    job_valid    = 1'b1;
    job_addr_src = {a1, a0};
    job_addr_dst = d;
    job_len      = l;
    tick();
    job_valid    = 1'b0;
  endtask

  // From CFG: no start in CFG, start pulse in T+2, returns in the first RUN cycle.
  task automatic start_to_run();
    @(negedge clk);
    chk("no_start_in_cfg", {62'd0, src_req_start == 2'b00, sink_req_start}, 64'd2);
    chk("err_clear_on_accept", {61'd0, err, err_code}, 64'd0);
    tick();
    @(negedge clk);
    chk("start_at_t2", {61'd0, src_req_start, sink_req_start}, 64'd7);
    tick();
  endtask

  task automatic stream(input int n);
    repeat (n) begin
      beat = 1'b1;
      tick();
    end
    beat = 1'b0;
  endtask

  task automatic pulse_done(input logic [1:0] s, input logic k);
    src_done  = s;
    sink_done = k;
    tick();
    src_done  = 2'b00;
    sink_done = 1'b0;
  endtask

  task automatic normal_job();
    push(1'b0, 2'd0, 32'd9, 1);
    accept(32'h100, 32'h200, 32'h300, 16'd8);
    @(negedge clk);
    chk("src_addr_latched", src_addr, 64'h0000_0200_0000_0100);
    chk("dst_len_latched", {dst_addr, 16'd0, len}, {32'h300, 16'd0, 16'd8});
    // start_to_run waits on the next negedge, so step back into the CFG-relative timing
    tick();
    @(negedge clk);
    chk("start_at_t2", {61'd0, src_req_start, sink_req_start}, 64'd7);
    tick();
    stream(8);
    pulse_done(2'b11, 1'b1);
    @(negedge clk);
    chk("done_after_last_done", {63'd0, done}, 64'd1);
    tick();
    tick();
  endtask

  always @(negedge clk) begin
    if (rst || clear) begin
      starts = 0;
    end else begin
      if (sink_req_start || (src_req_start != 2'b00)) begin
        starts++;
        chk("lockstep_start", {61'd0, src_req_start, sink_req_start}, 64'd7);
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done_o=1 expected no completion");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sb_err", {63'd0, err}, {63'd0, e.err});
          chk("sb_err_code", {62'd0, err_code}, {62'd0, e.code});
          chk("sb_cycles", {32'd0, cycles}, {32'd0, e.cycles});
          chk("sb_start_count", 64'(starts), 64'(e.starts));
        end
        starts = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; job_valid = 1'b0;
    job_addr_src = '0; job_addr_dst = '0; job_len = '0;
    src_ready_start = 2'b11; sink_ready_start = 1'b1;
    src_done = 2'b00; sink_done = 1'b0; beat = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready_busy_done", {61'd0, job_ready, busy, done}, 64'd4);
    chk("reset_err", {61'd0, err, err_code}, 64'd0);
    chk("reset_regs", src_addr | {dst_addr, cycles} | {48'd0, len}, 64'd0);
    tick();

    // basic job, all ready, 8 beats
    normal_job();

    // sink done 5 cycles before the last source done
    push(1'b0, 2'd0, 32'd14, 1);
    accept(32'h100, 32'h200, 32'h300, 16'd8);
    start_to_run();
    stream(8);
    pulse_done(2'b01, 1'b1);
    repeat (3) tick();
    @(negedge clk);
    chk("waits_for_last_done", {62'd0, busy, done}, 64'd2);
    tick();
    pulse_done(2'b10, 1'b0);
    tick();
    tick();

    // misaligned operand 0
    push(1'b1, 2'd1, 32'd0, 0);
    accept(32'h102, 32'h200, 32'h300, 16'd8);
    repeat (4) tick();
    @(negedge clk);
    chk("err_sticky_in_idle", {60'd0, err, err_code, job_ready}, {60'd0, 1'b1, 2'd1, 1'b1});
    tick();

    // timeout: source 0 never done
    push(1'b1, 2'd2, 32'd16, 1);
    accept(32'h100, 32'h200, 32'h300, 16'd4);
    start_to_run();
    stream(4);
    pulse_done(2'b10, 1'b1);
    repeat (11) tick();
    tick();

    // beat-count mismatch (also shows err cleared by this accept)
    push(1'b1, 2'd3, 32'd4, 1);
    accept(32'h400, 32'h800, 32'hC00, 16'd4);
    start_to_run();
    stream(3);
    pulse_done(2'b11, 1'b1);
    tick();
    tick();

    // zero length completes at T+2 without starting anything
    push(1'b0, 2'd0, 32'd0, 0);
    accept(32'h100, 32'h200, 32'h300, 16'd0);
    tick();
    @(negedge clk);
    chk("len0_done_at_t2", {63'd0, done}, 64'd1);
    tick();
    tick();

    // soft clear mid-RUN, then a normal job
    accept(32'h100, 32'h200, 32'h300, 16'd8);
    start_to_run();
    stream(3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    @(negedge clk);
    chk("clear_ready_busy_done", {61'd0, job_ready, busy, done}, 64'd4);
    chk("clear_regs", src_addr | {dst_addr, cycles} | {48'd0, len}, 64'd0);
    chk("clear_starts_err", {59'd0, src_req_start, sink_req_start, err, err_code == 2'd0}, 64'd1);
    tick();
    normal_job();

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
